// File: rtl/jtsbaskt_gfx_slots.sv
`default_nettype none
// ============================================================================
// Module   : jtsbaskt_gfx_slots
// Purpose  : Two-slot SDRAM read cache for the graphics ROMs. The scroll
//            slot is always enabled; the object slot is gated by obj_cs.
//            Each slot holds one 32-bit word, its address and a valid flag.
//            A single SDRAM read is outstanding at most, and scroll has
//            priority over object when both miss.
// Ports    : clk, rst            - system clock, async active-high reset
//            scr_addr/data/ok    - scroll slot request, word, hit flag
//            obj_cs/addr/data/ok - object slot enable, request, word, hit
//            sdram_addr/rd       - outgoing read address and request
//            sdram_ack/rdy/din   - controller accept, data strobe, data
// Revision : 1.0 - initial release
// ============================================================================
module jtsbaskt_gfx_slots #(
    parameter logic [21:0] SCR_OFFSET = 22'h00_8000,
    parameter logic [21:0] OBJ_OFFSET = 22'h01_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    input  logic        obj_cs,
    input  logic [13:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_rd,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [12:0] r_scr_addr;
    logic [31:0] r_scr_data;
    logic        r_scr_valid;
    logic [13:0] r_obj_addr;
    logic [31:0] r_obj_data;
    logic        r_obj_valid;

    // Request register: which slot the outstanding read belongs to and the
    // slot address it was issued for. The slot is written from here, not from
    // the live input, so an address change mid-read cannot corrupt the tag.
    logic        r_req_obj;
    logic [13:0] r_req_addr;
    logic [21:0] r_sdram_addr;
    logic        r_sdram_rd;

    logic        w_scr_miss;
    logic        w_obj_miss;
    logic        w_pick_obj;
    logic        w_launch;
    logic        w_accept;
    logic        w_store;
    logic [21:0] w_scr_req;
    logic [21:0] w_obj_req;

    assign scr_ok     = r_scr_valid && (scr_addr == r_scr_addr);
    assign obj_ok     = obj_cs && r_obj_valid && (obj_addr == r_obj_addr);
    assign scr_data   = r_scr_data;
    assign obj_data   = r_obj_data;
    assign sdram_addr = r_sdram_addr;
    assign sdram_rd   = r_sdram_rd;

    assign w_scr_miss = !scr_ok;
    assign w_obj_miss = obj_cs && !obj_ok;
    // Scroll has fixed priority; object is only picked when scroll hits.
    assign w_pick_obj = !w_scr_miss;

    // 22-bit sums wrap naturally modulo 2^22.
    assign w_scr_req  = SCR_OFFSET + {9'd0, scr_addr};
    assign w_obj_req  = OBJ_OFFSET + {8'd0, obj_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_scr_miss || w_obj_miss) begin
                    w_launch     = 1'b1;
                    w_state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (sdram_rdy) begin
                    w_store      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scr_addr   <= '0;
            r_scr_data   <= '0;
            r_scr_valid  <= 1'b0;
            r_obj_addr   <= '0;
            r_obj_data   <= '0;
            r_obj_valid  <= 1'b0;
            r_req_obj    <= 1'b0;
            r_req_addr   <= '0;
            r_sdram_addr <= '0;
            r_sdram_rd   <= 1'b0;
        end else begin
            if (w_launch) begin
                r_req_obj    <= w_pick_obj;
                r_req_addr   <= w_pick_obj ? obj_addr : {1'b0, scr_addr};
                r_sdram_addr <= w_pick_obj ? w_obj_req : w_scr_req;
                r_sdram_rd   <= 1'b1;
            end
            if (w_accept) begin
                r_sdram_rd <= 1'b0;
            end
            if (w_store) begin
                if (r_req_obj) begin
                    r_obj_addr  <= r_req_addr;
                    r_obj_data  <= sdram_din;
                    r_obj_valid <= 1'b1;
                end else begin
                    r_scr_addr  <= r_req_addr[12:0];
                    r_scr_data  <= sdram_din;
                    r_scr_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
